// File: rtl/ifu_imem_ctrl.sv
// Instruction-memory controller behind the fetch request/response channels.
// Drives a 1-cycle-latency SRAM and returns in-order responses through a 2-entry buffer.
module ifu_imem_ctrl #(
    parameter int                    PC_SIZE    = 32,
    parameter int                    INSTR_SIZE = 32,
    parameter int                    RAM_AW     = 14,
    parameter logic [PC_SIZE-1:0]    BASE_ADDR  = 32'h8000_0000,
    parameter logic [INSTR_SIZE-1:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [PC_SIZE-1:0]    ifu_req_pc,
    output logic                  ifu_rsp_valid,
    input  logic                  ifu_rsp_ready,
    output logic [INSTR_SIZE-1:0] ifu_rsp_instr,
    output logic                  ifu_rsp_err,
    output logic                  ram_cs,
    output logic [RAM_AW-1:0]     ram_addr,
    input  logic [INSTR_SIZE-1:0] ram_rdata
);

    logic [PC_SIZE-3:0] woff;
    logic               err_req;
    logic               accept;
    logic               push;
    logic               pop;

    logic               inflight_q, inflight_d;
    logic               inflight_err_q, inflight_err_d;
    logic [1:0]         cnt_q, cnt_d;
    logic               wptr_q, wptr_d;
    logic               rptr_q, rptr_d;

    logic [1:0][INSTR_SIZE-1:0] buf_instr_q, buf_instr_d;
    logic [1:0]                 buf_err_q, buf_err_d;

    logic [INSTR_SIZE-1:0] ret_data;
    logic                  ret_err;

    // Decode the request address and decide whether it can be accepted.
    always_comb begin
        woff          = ifu_req_pc[PC_SIZE-1:2] - BASE_ADDR[PC_SIZE-1:2];
        err_req       = (ifu_req_pc[1:0] != 2'b00) | (|woff[PC_SIZE-3:RAM_AW]);
        ifu_req_ready = !rst & ((cnt_q + {1'b0, inflight_q}) < 2'd2);
        accept        = ifu_req_valid & ifu_req_ready;
        ram_cs        = accept & !err_req;
        ram_addr      = woff[RAM_AW-1:0];
    end

    // Pick the response: buffer head first, else bypass from the return stage.
    always_comb begin
        ret_err       = inflight_err_q;
        ret_data      = inflight_err_q ? NOP_INSTR : ram_rdata;
        ifu_rsp_valid = 1'b0;
        ifu_rsp_instr = '0;
        ifu_rsp_err   = 1'b0;
        if (!rst) begin
            if (cnt_q != 2'd0) begin
                ifu_rsp_valid = 1'b1;
                ifu_rsp_instr = buf_instr_q[rptr_q];
                ifu_rsp_err   = buf_err_q[rptr_q];
            end else if (inflight_q) begin
                ifu_rsp_valid = 1'b1;
                ifu_rsp_instr = ret_data;
                ifu_rsp_err   = ret_err;
            end
        end
    end

    // Next-state for the return stage and the response buffer.
    always_comb begin
        pop            = ifu_rsp_valid & ifu_rsp_ready & (cnt_q != 2'd0);
        push           = inflight_q & !((cnt_q == 2'd0) & ifu_rsp_ready);
        inflight_d     = accept;
        inflight_err_d = accept & err_req;
        buf_instr_d    = buf_instr_q;
        buf_err_d      = buf_err_q;
        wptr_d         = wptr_q;
        rptr_d         = rptr_q;
        if (push) begin
            buf_instr_d[wptr_q] = ret_data;
            buf_err_d[wptr_q]   = ret_err;
            wptr_d              = ~wptr_q;
        end
        if (pop) begin
            rptr_d = ~rptr_q;
        end
        cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end

    // Control state, cleared by reset so pending work is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q     <= 1'b0;
            inflight_err_q <= 1'b0;
            cnt_q          <= 2'd0;
            wptr_q         <= 1'b0;
            rptr_q         <= 1'b0;
        end else begin
            inflight_q     <= inflight_d;
            inflight_err_q <= inflight_err_d;
            cnt_q          <= cnt_d;
            wptr_q         <= wptr_d;
            rptr_q         <= rptr_d;
        end
    end

    // Buffer payload; only meaningful when counted, so no reset needed.
    always_ff @(posedge clk) begin
        buf_instr_q <= buf_instr_d;
        buf_err_q   <= buf_err_d;
    end

    // Returned data must never land in a full buffer.
    a_no_push_full: assert property (
        @(posedge clk) disable iff (rst) !(push && cnt_q == 2'd2)
    );

endmodule

// File: tb/tb_ifu_imem_ctrl.sv
// Bench for ifu_imem_ctrl: directed plan scenarios plus random traffic,
// all checked against a queue-based model of outstanding fetches.
module tb_ifu_imem_ctrl;

    localparam int          AW   = 14;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    typedef struct packed {
        logic        err;
        logic [31:0] instr;
    } rsp_t;

    logic          clk;
    logic          rst;
    logic          ifu_req_valid;
    logic          ifu_req_ready;
    logic [31:0]   ifu_req_pc;
    logic          ifu_rsp_valid;
    logic          ifu_rsp_ready;
    logic [31:0]   ifu_rsp_instr;
    logic          ifu_rsp_err;
    logic          ram_cs;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_rdata;

    logic [31:0] mem [0:(1<<AW)-1];

    int   checks = 0;
    int   errors = 0;
    int   n_acc  = 0;
    int   stalls = 0;
    rsp_t exp_q[$];
    rsp_t got_q[$];
    logic hold_v = 1'b0;
    rsp_t hold_r;

    ifu_imem_ctrl #(
        .PC_SIZE(32), .INSTR_SIZE(32), .RAM_AW(AW),
        .BASE_ADDR(BASE), .NOP_INSTR(NOP)
    ) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
        .ifu_req_pc(ifu_req_pc),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready),
        .ifu_rsp_instr(ifu_rsp_instr), .ifu_rsp_err(ifu_rsp_err),
        .ram_cs(ram_cs), .ram_addr(ram_addr), .ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM: 1-cycle read; output is garbage when not selected
    always @(posedge clk) begin
        if (ram_cs) ram_rdata <= mem[ram_addr];
        else        ram_rdata <= $urandom;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_got(input string nm, input int idx,
                           input logic [31:0] ins, input logic er);
        checks++;
        if (idx >= got_q.size()) begin
            errors++;
            $display("FAIL %s: response %0d missing, expected %h/%0b", nm, idx, ins, er);
        end else if (got_q[idx] !== {er, ins}) begin
            errors++;
            $display("FAIL %s: got %h/%0b expected %h/%0b", nm,
                     got_q[idx].instr, got_q[idx].err, ins, er);
        end
    endtask

    // Expected response for a fetch address, straight from the address map
    function automatic rsp_t model(input logic [31:0] pc);
        logic [31:0] off;
        rsp_t r;
        off = pc - BASE;
        if (pc[1:0] != 2'b00 || off >= (32'd4 << AW)) begin
            r.err = 1'b1;
            r.instr = NOP;
        end else begin
            r.err = 1'b0;
            r.instr = mem[off[AW+1:2]];
        end
        return r;
    endfunction

    // Compare process: outstanding fetches = exp_q; checked every cycle
    always @(negedge clk) begin
        rsp_t e;
        logic acc;
        if (rst) begin
            chk("rst_req_ready", 32'(ifu_req_ready), 32'd0);
            chk("rst_rsp_valid", 32'(ifu_rsp_valid), 32'd0);
            chk("rst_ram_cs", 32'(ram_cs), 32'd0);
            chk("rst_rsp_instr", ifu_rsp_instr, 32'd0);
            chk("rst_rsp_err", 32'(ifu_rsp_err), 32'd0);
            exp_q.delete();
            hold_v = 1'b0;
        end else begin
            chk("req_ready", 32'(ifu_req_ready), 32'(exp_q.size() < 2));
            chk("rsp_valid", 32'(ifu_rsp_valid), 32'(exp_q.size() != 0));
            if (ifu_rsp_valid && exp_q.size() != 0) begin
                chk("rsp_instr", ifu_rsp_instr, exp_q[0].instr);
                chk("rsp_err", 32'(ifu_rsp_err), 32'(exp_q[0].err));
            end
            if (hold_v) begin
                chk("hold_valid", 32'(ifu_rsp_valid), 32'd1);
                chk("hold_instr", ifu_rsp_instr, hold_r.instr);
                chk("hold_err", 32'(ifu_rsp_err), 32'(hold_r.err));
            end
            e   = model(ifu_req_pc);
            acc = ifu_req_valid && (exp_q.size() < 2);
            chk("ram_cs", 32'(ram_cs), 32'(acc && !e.err));
            if (acc && !e.err)
                chk("ram_addr", 32'(ram_addr), (ifu_req_pc - BASE) >> 2);
            hold_v = ifu_rsp_valid && !ifu_rsp_ready;
            hold_r = {ifu_rsp_err, ifu_rsp_instr};
            if (ifu_rsp_valid && ifu_rsp_ready) begin
                got_q.push_back({ifu_rsp_err, ifu_rsp_instr});
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            if (acc) begin
                exp_q.push_back(e);
                n_acc++;
            end
        end
    end

    // Present one request and hold it until accepted (bounded)
    task automatic send(input logic [31:0] pc);
        int n;
        n = 0;
        ifu_req_valid = 1'b1;
        ifu_req_pc = pc;
        @(negedge clk);
        while (!ifu_req_ready && n < 200) begin
            n++;
            stalls++;
            @(negedge clk);
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: pc %h never accepted", pc);
        end
        @(posedge clk);
        #1;
        ifu_req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d responses outstanding", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] w;
        w = 32'($urandom_range(0, 63)) << 2;
        case ($urandom_range(0, 9))
            0:       return BASE + w + 32'($urandom_range(1, 3));
            1:       return BASE - 32'd4 * 32'($urandom_range(1, 8));
            2:       return BASE + (32'd4 << AW) + w;
            3:       return BASE + (32'd4 << AW) - 32'd4;
            default: return BASE + w;
        endcase
    endfunction

    initial begin
        int b;
        int a0;
        rst = 1'b1;
        ifu_req_valid = 1'b1;
        ifu_req_pc = BASE;
        ifu_rsp_ready = 1'b1;
        for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
        mem[0] = 32'h0000_0013;
        mem[1] = 32'h0010_0093;
        mem[2] = 32'h0020_0113;
        mem[3] = 32'h0030_0193;

        // reset with a request pending
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        ifu_req_valid = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(ifu_req_ready), 32'd1);
        @(posedge clk);
        #1;

        // streaming at full rate
        b = got_q.size();
        stalls = 0;
        for (int i = 0; i < 4; i++) send(BASE + 32'(4 * i));
        drain();
        chk("stream_stalls", 32'(stalls), 32'd0);
        chk_got("stream0", b + 0, 32'h0000_0013, 1'b0);
        chk_got("stream1", b + 1, 32'h0010_0093, 1'b0);
        chk_got("stream2", b + 2, 32'h0020_0113, 1'b0);
        chk_got("stream3", b + 3, 32'h0030_0193, 1'b0);

        // back-pressure: only two accepted while consumer stalls
        ifu_rsp_ready = 1'b0;
        b = got_q.size();
        a0 = n_acc;
        fork
            begin
                send(BASE);
                send(BASE + 32'd4);
                send(BASE + 32'd8);
            end
            begin
                repeat (6) @(negedge clk);
                chk("bp_accepts", 32'(n_acc - a0), 32'd2);
                chk("bp_req_ready", 32'(ifu_req_ready), 32'd0);
                @(posedge clk);
                #1;
                ifu_rsp_ready = 1'b1;
            end
        join
        drain();
        chk_got("bp0", b + 0, 32'h0000_0013, 1'b0);
        chk_got("bp1", b + 1, 32'h0010_0093, 1'b0);
        chk_got("bp2", b + 2, 32'h0020_0113, 1'b0);

        // access faults
        b = got_q.size();
        send(32'h8000_0002);
        send(32'h7FFF_FFFC);
        send(32'h8001_0000);
        drain();
        chk_got("fault0", b + 0, NOP, 1'b1);
        chk_got("fault1", b + 1, NOP, 1'b1);
        chk_got("fault2", b + 2, NOP, 1'b1);

        // mixed good/fault with toggling consumer
        b = got_q.size();
        fork
            begin
                for (int i = 0; i < 12; i++) begin
                    ifu_rsp_ready = (i % 2 == 0);
                    @(posedge clk);
                    #1;
                end
            end
            begin
                send(32'h8000_0004);
                send(32'h8000_0001);
                send(32'h8000_0008);
            end
        join
        ifu_rsp_ready = 1'b1;
        drain();
        chk("mixed_count", 32'(got_q.size() - b), 32'd3);
        chk_got("mixed0", b + 0, 32'h0010_0093, 1'b0);
        chk_got("mixed1", b + 1, NOP, 1'b1);
        chk_got("mixed2", b + 2, 32'h0020_0113, 1'b0);

        // reset with two responses buffered
        ifu_rsp_ready = 1'b0;
        send(BASE + 32'd12);
        send(BASE);
        @(posedge clk);
        #1;
        chk("full_req_ready", 32'(ifu_req_ready), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", 32'(ifu_rsp_valid), 32'd0);
        chk("mid_rst_ready", 32'(ifu_req_ready), 32'd1);
        @(posedge clk);
        #1;
        ifu_rsp_ready = 1'b1;
        b = got_q.size();
        send(BASE + 32'd8);
        drain();
        chk("mid_rst_count", 32'(got_q.size() - b), 32'd1);
        chk_got("mid_rst_data", b, 32'h0020_0113, 1'b0);

        // random traffic with occasional reset
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            ifu_req_valid = ($urandom_range(0, 3) != 0);
            ifu_req_pc = rand_pc();
            ifu_rsp_ready = ($urandom_range(0, 2) != 0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        ifu_req_valid = 1'b0;
        ifu_rsp_ready = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
